sbus_mem_ctl: RTL and testbench
===============================

SBUS_MEM_CTL -- requirements
Module: sbus_mem_ctl

Interface
REQ-001 clk  input  1  system clock; all state changes on posedge clk.
REQ-002 CROBAR_N  input  1  reset; one clock; reset is synchronous and active-low.
REQ-003 REQ  input  [0:1]  per-requester request; held until matching GNT bit.
REQ-004 REQ_ADR0, REQ_ADR1  input  [14:35] each  requester word address; ADR[34:35] is the starting word offset.
REQ-005 REQ_RQ0, REQ_RQ1  input  [0:3] each  quadword word-request mask; bit k requests the k-th word after the start.
REQ-006 GNT  output  [0:1]  one-cycle acceptance pulse, at most one bit set.
REQ-007 START  output  1  SBUS start for one memory phase.
REQ-008 ADR  output  [14:35]  SBUS address, valid while START=1.
REQ-009 RQ  output  [0:3]  SBUS request mask, valid while START=1.
REQ-010 ACKN, VALID  input  1 each  memory acknowledge and data-valid.
REQ-011 D  input  [0:35]  memory read data.
REQ-012 PARITY  input  1  memory data parity (even XOR of D).
REQ-013 RD_DATA  output  [0:35]  registered copy of D.
REQ-014 RD_WO  output  [34:35]  word offset of RD_DATA.
REQ-015 RD_VALID  output  [0:1]  per-requester data strobe for RD_DATA.
REQ-016 DONE  output  [0:1]  one-cycle end-of-transfer pulse to owning requester.
REQ-017 ERR  output  [0:1]  error code, qualified by DONE: 00 ok, 01 parity, 10 NXM.
REQ-018 BUSY  output  1  1 in any state other than IDLE.

Function
REQ-019 States: IDLE, ISSUE, XFER, FIN; one transfer outstanding at a time.
REQ-020 IDLE with any REQ bit set -> arbitrate; winner recorded; next state ISSUE.
REQ-021 Arbitration: round-robin; with both set, the requester not granted last wins; with one set, it wins.
REQ-022 ISSUE: GNT[winner]=1; latch winner ADR/RQ; START=1, ADR, RQ driven for exactly this one cycle; next XFER with k=0.
REQ-023 ISSUE with latched RQ=0000: GNT pulses, START stays 0, next FIN with ERR=00.
REQ-024 XFER cycle k (0..3): expected = RQ[k]; if expected and VALID -> RD_DATA<=D, RD_WO<=ADR[34:35]+k (mod 4), RD_VALID[winner] pulses the following cycle.
REQ-025 VALID while not expected: ignored, no RD_VALID.
REQ-026 Expected word with PARITY != XOR of D: word still delivered; sticky parity error set.
REQ-027 XFER exits to FIN after cycle k when RQ[k+1:3] all zero; k never exceeds 3.
REQ-028 FIN: DONE[winner]=1 for one cycle with ERR (NXM over parity if both); next IDLE; REQ sampled again in IDLE only.
REQ-029 ACKN monitored only for NXM (REQ-035); controller never issues while a transfer is in XFER.
REQ-030 REQ dropped by a requester before GNT: request withdrawn, no effect.

Reset
REQ-031 CROBAR_N=0 at posedge clk: state IDLE, k=0, all error flags clear, last-granted = requester 1 (requester 0 wins first tie).
REQ-032 Reset values: GNT=00, START=0, ADR=0, RQ=0000, RD_DATA=0, RD_WO=00, RD_VALID=00, DONE=00, ERR=00, BUSY=0.
REQ-033 Reset mid-transfer: abort immediately, no DONE issued; in-flight memory VALIDs after reset ignored.

Configuration
REQ-034 Macro SBUS_MEM_CTL_NXM_EN selects nonexistent-memory detection.
REQ-035 Defined: in XFER cycle k with RQ[k]=1 and ACKN=0 or VALID=0, set NXM, abort remaining words, go FIN with ERR=10.
REQ-036 Undefined: missing word silently skipped, no RD_VALID, transfer continues per REQ-027; ERR never 10.

Verification
REQ-037 REQ=10, ADR0=000100 octal, RQ0=1111, memory words 1,2,3,4 -> GNT=10, one START, RD_VALID[0] x4 with RD_WO 0,1,2,3, DONE=10 ERR=00.
REQ-038 REQ=11 held for two transfers -> GNT order 10 then 01; second GNT not before first DONE.
REQ-039 RQ1=0101, ADR1[34:35]=10 -> RD_VALID[1] twice with RD_WO 11 then 01; DONE after XFER cycle 3.
REQ-040 RQ0=0000 -> GNT pulse, START never 1, DONE=10 ERR=00 two cycles later.
REQ-041 Word 2 delivered with flipped PARITY -> all words delivered, DONE ERR=01.
REQ-042 NXM_EN, memory absent (ACKN=VALID=0), RQ=1111 -> no RD_VALID, DONE ERR=10 after XFER cycle 0; without macro -> DONE ERR=00 after cycle 3.

Source files
------------

// File: rtl/sbus_mem_ctl.sv
// sbus_mem_ctl: two-requester SBUS memory read controller.
// Arbitrates round-robin between two requesters, issues one SBUS start per
// transfer, collects up to four words of a quadword and returns them with
// per-requester strobes. One transfer is outstanding at a time.
//
// Build option: define SBUS_MEM_CTL_NXM_EN to enable nonexistent-memory
// detection (missing ACKN/VALID on a requested word aborts with ERR=10).
// Without it a missing word is skipped silently.
//
// Ports:
//   clk                  system clock, all state on posedge
//   CROBAR_N             synchronous active-low reset
//   REQ[0:1]             per-requester request, held until GNT
//   REQ_ADR0/1[14:35]    requester word address, [34:35] = start offset
//   REQ_RQ0/1[0:3]       requester word mask relative to start offset
//   GNT[0:1]             one-cycle acceptance pulse
//   START, ADR, RQ       SBUS start strobe with address and mask
//   ACKN, VALID, D, PARITY  memory acknowledge, data strobe, data, parity
//   RD_DATA, RD_WO       last delivered word and its word offset
//   RD_VALID[0:1]        per-requester delivery strobe
//   DONE[0:1], ERR[0:1]  end-of-transfer pulse and its error code
//   BUSY                 controller not idle
module sbus_mem_ctl (
  input  logic         clk,
  input  logic         CROBAR_N,
  input  logic [0:1]   REQ,
  input  logic [14:35] REQ_ADR0,
  input  logic [14:35] REQ_ADR1,
  input  logic [0:3]   REQ_RQ0,
  input  logic [0:3]   REQ_RQ1,
  output logic [0:1]   GNT,
  output logic         START,
  output logic [14:35] ADR,
  output logic [0:3]   RQ,
  input  logic         ACKN,
  input  logic         VALID,
  input  logic [0:35]  D,
  input  logic         PARITY,
  output logic [0:35]  RD_DATA,
  output logic [34:35] RD_WO,
  output logic [0:1]   RD_VALID,
  output logic [0:1]   DONE,
  output logic [0:1]   ERR,
  output logic         BUSY
);

  localparam int unsigned WO_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  // Transfer state
  state_t            state, state_nxt;
  logic [WO_W-1:0]   k, k_nxt;
  logic              win, win_nxt;
  logic              last, last_nxt;
  logic [0:3]        rq_l, rq_l_nxt;
  logic [WO_W-1:0]   base, base_nxt;
  logic              par_err, par_nxt;
  logic              nxm_err, nxm_nxt;

  // Next values of the registered outputs
  logic [0:1]        gnt_nxt;
  logic              start_nxt;
  logic [14:35]      adr_nxt;
  logic [0:3]        rq_nxt;
  logic [0:35]       rd_data_nxt;
  logic [34:35]      rd_wo_nxt;
  logic [0:1]        rd_valid_nxt;
  logic [0:1]        done_nxt;
  logic [0:1]        err_nxt;
  logic              busy_nxt;

  // Combinational helpers
  logic              arb_win;
  logic [14:35]      sel_adr;
  logic [0:3]        sel_rq;
  logic [0:1]        win_oh;
  logic              more;
  logic              word_ok;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    if (REQ[0] && REQ[1]) arb_win = ~last;
    else                  arb_win = REQ[1];
  end

  assign sel_adr = arb_win ? REQ_ADR1 : REQ_ADR0;
  assign sel_rq  = arb_win ? REQ_RQ1  : REQ_RQ0;
  assign win_oh  = win ? 2'b01 : 2'b10;

  // Any requested word still ahead of the current slot.
  always_comb begin
    case (k)
      2'd0:    more = |rq_l[1:3];
      2'd1:    more = |rq_l[2:3];
      2'd2:    more = rq_l[3];
      default: more = 1'b0;
    endcase
  end

`ifndef SBUS_MEM_CTL_NXM_EN
  // ACKN only matters for nonexistent-memory detection.
  logic unused_ackn;
  assign unused_ackn = ACKN;
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    win_nxt      = win;
    last_nxt     = last;
    rq_l_nxt     = rq_l;
    base_nxt     = base;
    par_nxt      = par_err;
    nxm_nxt      = nxm_err;
    gnt_nxt      = 2'b00;
    start_nxt    = 1'b0;
    adr_nxt      = '0;
    rq_nxt       = 4'b0000;
    rd_data_nxt  = RD_DATA;
    rd_wo_nxt    = RD_WO;
    rd_valid_nxt = 2'b00;
    done_nxt     = 2'b00;
    err_nxt      = 2'b00;
    word_ok      = 1'b0;

    case (state)
      S_IDLE: begin
        if (|REQ) begin
          win_nxt   = arb_win;
          last_nxt  = arb_win;
          rq_l_nxt  = sel_rq;
          base_nxt  = sel_adr[34:35];
          par_nxt   = 1'b0;
          nxm_nxt   = 1'b0;
          k_nxt     = '0;
          // Outputs register on entry so they are visible during ISSUE.
          gnt_nxt   = arb_win ? 2'b01 : 2'b10;
          start_nxt = |sel_rq;
          if (|sel_rq) begin
            adr_nxt = sel_adr;
            rq_nxt  = sel_rq;
          end
          state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        k_nxt = '0;
        if (rq_l == 4'b0000) state_nxt = S_FIN;
        else                 state_nxt = S_XFER;
      end

      S_XFER: begin
        if (rq_l[k]) begin
`ifdef SBUS_MEM_CTL_NXM_EN
          word_ok = ACKN && VALID;
          if (!word_ok) nxm_nxt = 1'b1;
`else
          word_ok = VALID;
`endif
          if (word_ok) begin
            rd_data_nxt  = D;
            rd_wo_nxt    = base + k;
            rd_valid_nxt = win_oh;
            if (PARITY != ^D) par_nxt = 1'b1;
          end
        end
        if (nxm_nxt || !more) state_nxt = S_FIN;
        else                  k_nxt     = k + WO_W'(1);
      end

      S_FIN: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // DONE/ERR register on entry to FIN; NXM outranks parity.
    if ((state_nxt == S_FIN) && (state != S_FIN)) begin
      done_nxt = win_oh;
      if (nxm_nxt)      err_nxt = 2'b10;
      else if (par_nxt) err_nxt = 2'b01;
      else              err_nxt = 2'b00;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!CROBAR_N) begin
      state    <= S_IDLE;
      k        <= '0;
      win      <= 1'b0;
      last     <= 1'b1;
      rq_l     <= 4'b0000;
      base     <= '0;
      par_err  <= 1'b0;
      nxm_err  <= 1'b0;
      GNT      <= 2'b00;
      START    <= 1'b0;
      ADR      <= '0;
      RQ       <= 4'b0000;
      RD_DATA  <= '0;
      RD_WO    <= 2'b00;
      RD_VALID <= 2'b00;
      DONE     <= 2'b00;
      ERR      <= 2'b00;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      win      <= win_nxt;
      last     <= last_nxt;
      rq_l     <= rq_l_nxt;
      base     <= base_nxt;
      par_err  <= par_nxt;
      nxm_err  <= nxm_nxt;
      GNT      <= gnt_nxt;
      START    <= start_nxt;
      ADR      <= adr_nxt;
      RQ       <= rq_nxt;
      RD_DATA  <= rd_data_nxt;
      RD_WO    <= rd_wo_nxt;
      RD_VALID <= rd_valid_nxt;
      DONE     <= done_nxt;
      ERR      <= err_nxt;
      BUSY     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sbus_mem_ctl.sv
// tb_sbus_mem_ctl: directed bench for sbus_mem_ctl. A transaction-level model
// predicts the outputs of every cycle; one negedge process compares them.
module tb_sbus_mem_ctl;

  logic         clk = 1'b0;
  logic         CROBAR_N;
  logic [0:1]   REQ;
  logic [14:35] REQ_ADR0, REQ_ADR1;
  logic [0:3]   REQ_RQ0, REQ_RQ1;
  logic [0:1]   GNT;
  logic         START;
  logic [14:35] ADR;
  logic [0:3]   RQ;
  logic         ACKN, VALID;
  logic [0:35]  D;
  logic         PARITY;
  logic [0:35]  RD_DATA;
  logic [34:35] RD_WO;
  logic [0:1]   RD_VALID;
  logic [0:1]   DONE;
  logic [0:1]   ERR;
  logic         BUSY;

  sbus_mem_ctl dut (
    .clk(clk), .CROBAR_N(CROBAR_N), .REQ(REQ),
    .REQ_ADR0(REQ_ADR0), .REQ_ADR1(REQ_ADR1),
    .REQ_RQ0(REQ_RQ0), .REQ_RQ1(REQ_RQ1),
    .GNT(GNT), .START(START), .ADR(ADR), .RQ(RQ),
    .ACKN(ACKN), .VALID(VALID), .D(D), .PARITY(PARITY),
    .RD_DATA(RD_DATA), .RD_WO(RD_WO), .RD_VALID(RD_VALID),
    .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit           chk;
    logic [0:1]   gnt;
    logic         start;
    logic [14:35] adr;
    logic [0:3]   rq;
    logic [0:35]  rd_data;
    logic [1:0]   rd_wo;
    logic [0:1]   rd_valid;
    logic [0:1]   done;
    logic [0:1]   err;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int checks = 0;
  int failures = 0;

  // Model state
  logic [0:35] m_rd_data = '0;
  logic [1:0]  m_rd_wo = 2'b00;
  bit          m_last = 1'b1;

  // Per-transaction records used for the literal pins
  int          dl_wo[$];
  logic [0:35] dl_data[$];
  logic [0:1]  m_gnt_log[$];
  int          m_err;
  int          m_xfer_cycles;
  int          m_starts;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.chk = 1'b1; e.gnt = 2'b00; e.start = 1'b0; e.adr = '0; e.rq = 4'b0000;
    e.rd_data = m_rd_data; e.rd_wo = m_rd_wo; e.rd_valid = 2'b00;
    e.done = 2'b00; e.err = 2'b00; e.busy = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.chk) begin
        check("gnt",      64'(GNT),      64'(cur.gnt));
        check("start",    64'(START),    64'(cur.start));
        check("adr",      64'(ADR),      64'(cur.adr));
        check("rq",       64'(RQ),       64'(cur.rq));
        check("rd_data",  64'(RD_DATA),  64'(cur.rd_data));
        check("rd_wo",    64'(RD_WO),    64'(cur.rd_wo));
        check("rd_valid", 64'(RD_VALID), 64'(cur.rd_valid));
        check("done",     64'(DONE),     64'(cur.done));
        check("err",      64'(ERR),      64'(cur.err));
        check("busy",     64'(BUSY),     64'(cur.busy));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input bit stray);
    tick();
    REQ = 2'b00; ACKN = stray; VALID = stray; D = 36'hABC; PARITY = 1'b0;
    exp_q.push_back(idle_exp());
  endtask

  // One transaction from the IDLE cycle that presents REQ to the FIN cycle.
  // present[k]: memory answers slot k; badpar[k]: parity flipped on slot k.
  // cut > 0 stops after that many cycles (used for the reset-abort case).
  task automatic txn(input logic [0:1] pat, input logic [14:35] a0, input logic [14:35] a1,
                     input logic [0:3] m0, input logic [0:3] m1, input logic [0:3] present,
                     input logic [0:3] badpar, input logic [0:35] dbase, input int cut);
    bit w, par, nxm, stop, more;
    logic [14:35] a;
    logic [0:3] m;
    logic [0:1] oh, pend;
    logic [0:35] dw;
    int cyc;
    exp_t e;
    if (pat[0] && pat[1]) w = !m_last;
    else                  w = pat[1];
    m_last = w;
    a  = w ? a1 : a0;
    m  = w ? m1 : m0;
    oh = w ? 2'b01 : 2'b10;
    dl_wo.delete(); dl_data.delete();
    m_xfer_cycles = 0; m_err = -1; m_starts = 0;
    m_gnt_log.push_back(oh);
    cyc = 0;

    tick();
    REQ = pat; REQ_ADR0 = a0; REQ_ADR1 = a1; REQ_RQ0 = m0; REQ_RQ1 = m1;
    ACKN = 1'b0; VALID = 1'b0; D = '0; PARITY = 1'b0;
    exp_q.push_back(idle_exp());
    cyc++;
    if (cyc == cut) return;

    tick();
    e = idle_exp(); e.gnt = oh; e.start = (m != 4'b0000); e.busy = 1'b1;
    if (e.start) begin e.adr = a; e.rq = m; m_starts++; end
    exp_q.push_back(e);
    cyc++;
    if (cyc == cut) return;

    pend = 2'b00; par = 1'b0; nxm = 1'b0;
    if (m != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        e = idle_exp(); e.busy = 1'b1; e.rd_valid = pend;
        exp_q.push_back(e);
        pend = 2'b00;
        m_xfer_cycles++;
        dw = dbase + 36'(k + 1);
        if (m[k]) begin
          ACKN = present[k]; VALID = present[k];
          D = present[k] ? dw : '0;
          PARITY = (^D) ^ badpar[k];
          if (present[k]) begin
            m_rd_data = dw;
            m_rd_wo   = 2'(int'(a[34:35]) + k);
            pend      = oh;
            dl_wo.push_back(int'(m_rd_wo));
            dl_data.push_back(dw);
            if (badpar[k]) par = 1'b1;
          end else begin
`ifdef SBUS_MEM_CTL_NXM_EN
            nxm = 1'b1;
`endif
          end
        end else begin
          // stray strobe on a slot nobody asked for
          ACKN = 1'b1; VALID = 1'b1; D = ~dw; PARITY = 1'b0;
        end
        cyc++;
        more = 1'b0;
        for (int j = k + 1; j < 4; j++) if (m[j]) more = 1'b1;
        stop = nxm || !more;
        if (cyc == cut) return;
        if (stop) break;
      end
    end

    tick();
    ACKN = 1'b0; VALID = 1'b0; D = '0; PARITY = 1'b0;
    e = idle_exp(); e.busy = 1'b1; e.rd_valid = pend; e.done = oh;
    e.err = nxm ? 2'b10 : (par ? 2'b01 : 2'b00);
    exp_q.push_back(e);
    m_err = int'(e.err);
  endtask

  initial begin
    CROBAR_N = 1'b0; REQ = 2'b00; REQ_ADR0 = '0; REQ_ADR1 = '0;
    REQ_RQ0 = 4'b0000; REQ_RQ1 = 4'b0000; ACKN = 1'b0; VALID = 1'b0;
    D = '0; PARITY = 1'b0;

    // Reset
    tick(); exp_q.push_back(idle_exp());
    tick(); CROBAR_N = 1'b1; exp_q.push_back(idle_exp());
    check("rst_gnt",  64'(GNT),     64'd0);
    check("rst_busy", 64'(BUSY),    64'd0);
    check("rst_data", 64'(RD_DATA), 64'd0);
    idle_step(1'b1);

    // Both requesting, held across two transfers: 0 first, then 1
    m_gnt_log.delete();
    txn(2'b11, 22'o100, 22'o202, 4'b1111, 4'b1010, 4'b1111, 4'b0000, 36'h100, 0);
    txn(2'b11, 22'o100, 22'o202, 4'b1111, 4'b1010, 4'b1111, 4'b0000, 36'h200, 0);
    check("order_first",  64'(m_gnt_log[0]), 64'(2'b10));
    check("order_second", 64'(m_gnt_log[1]), 64'(2'b01));
    idle_step(1'b0); idle_step(1'b1);

    // Four-word read from octal 100
    txn(2'b10, 22'o100, 22'o0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 36'h0, 0);
    check("quad_count", 64'(dl_wo.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("quad_wo",   64'(dl_wo[i]),   64'(i));
      check("quad_data", 64'(dl_data[i]), 64'(i + 1));
    end
    check("quad_err", 64'(m_err), 64'd0);

    // Sparse mask with wrap: offsets 3 then 1
    txn(2'b01, 22'o0, 22'o202, 4'b0000, 4'b0101, 4'b1111, 4'b0000, 36'h300, 0);
    check("sparse_count", 64'(dl_wo.size()), 64'd2);
    check("sparse_wo0",   64'(dl_wo[0]), 64'd3);
    check("sparse_wo1",   64'(dl_wo[1]), 64'd1);
    check("sparse_slots", 64'(m_xfer_cycles), 64'd4);

    // Empty mask: grant, no start, immediate DONE
    txn(2'b10, 22'o440, 22'o0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 36'h0, 0);
    check("empty_starts", 64'(m_starts), 64'd0);
    check("empty_slots",  64'(m_xfer_cycles), 64'd0);
    check("empty_err",    64'(m_err), 64'd0);

    // Parity error on word 2: all words still delivered
    txn(2'b10, 22'o1001, 22'o0, 4'b1111, 4'b0000, 4'b1111, 4'b0010, 36'h400, 0);
    check("par_count", 64'(dl_wo.size()), 64'd4);
    check("par_err",   64'(m_err), 64'd1);

    // Memory absent
    txn(2'b10, 22'o7700, 22'o0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 36'h500, 0);
    check("nxm_count", 64'(dl_wo.size()), 64'd0);
`ifdef SBUS_MEM_CTL_NXM_EN
    check("nxm_err",   64'(m_err), 64'd2);
    check("nxm_slots", 64'(m_xfer_cycles), 64'd1);
`else
    check("nxm_err",   64'(m_err), 64'd0);
    check("nxm_slots", 64'(m_xfer_cycles), 64'd4);
`endif

    // Reset in the middle of a transfer, memory keeps strobing afterwards
    txn(2'b01, 22'o0, 22'o303, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 36'h600, 4);
    tick();
    CROBAR_N = 1'b0; ACKN = 1'b1; VALID = 1'b1; D = 36'h777; PARITY = 1'b1;
    cur = idle_exp(); cur.chk = 1'b0; exp_q.push_back(cur);
    m_rd_data = '0; m_rd_wo = 2'b00; m_last = 1'b1;
    tick();
    CROBAR_N = 1'b1; REQ = 2'b00; exp_q.push_back(idle_exp());
    check("abort_done", 64'(DONE),    64'd0);
    check("abort_data", 64'(RD_DATA), 64'd0);
    idle_step(1'b1); idle_step(1'b1);

    // Tie after reset goes to requester 0 again
    m_gnt_log.delete();
    txn(2'b11, 22'o12, 22'o21, 4'b1000, 4'b0001, 4'b1111, 4'b0000, 36'h800, 0);
    check("post_rst_tie", 64'(m_gnt_log[0]), 64'(2'b10));
    idle_step(1'b0); idle_step(1'b0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
